output_vc_tracker: RTL and testbench

Upstream-side counterpart of the input-port status buffer. It sits on one router output port and tracks the state of every virtual channel in the downstream router's input buffer. It consumes the per-VC on/off flow-control signals driven back by the downstream buffers and answers VC-allocation requests from local input VCs with a downstream VC index. It frees a VC when that VC's tail flit leaves on the link.

---
 rtl/params_noc.sv | 7 +
 rtl/rr_arbiter.sv | 17 +
 rtl/output_vc_tracker.sv | 90 +++++++++
 tb/tb_output_vc_tracker.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/params_noc.sv
// params_noc: shared NoC widths, flit types and downstream VC state encoding.
package params_noc;
  localparam int VC_NUM  = 2;
  localparam int VC_Size = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_e;
  typedef enum logic {FREE, ALLOCATED} vc_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr_i + 1 and wrapping.
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic [N-1:0] w_mask, w_hi, w_pick;
  for (genvar j = 0; j < N; j++) begin : g_mask
    assign w_mask[j] = PW'(j) > ptr_i;
  end
  assign w_hi   = req_i & w_mask;
  assign w_pick = |w_hi ? w_hi : req_i;
  assign gnt_o  = w_pick & (~w_pick + N'(1));
endmodule

// File: rtl/output_vc_tracker.sv
// output_vc_tracker: tracks downstream VC state for one output port and allocates free VCs.
// Define OUTPUT_VC_CHECK_EN to build the sticky protocol-error detector behind err_o.
module output_vc_tracker #(
  parameter int VC_NUM  = params_noc::VC_NUM,
  parameter int NUM_REQ = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             vc_Req_i,
  output logic [NUM_REQ-1:0]             vc_Grant_o,
  output logic [params_noc::VC_Size-1:0] vc_New_o,
  output logic                           vc_Val_o,
  input  logic [VC_NUM-1:0]              on_Off_i,
  input  logic                           flit_Sent_i,
  input  logic [params_noc::VC_Size-1:0] flit_Vc_i,
  input  logic                           flit_Tail_i,
  output logic [VC_NUM-1:0]              vc_Avail_o,
  output logic                           err_o
);
  import params_noc::*;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VP = 2 ** VC_Size;
  vc_state_e          r_state [VC_NUM];
  logic [NUM_REQ-1:0] r_grant, w_elig, w_gnt;
  logic [VC_Size-1:0] r_new, w_vc_sel;
  logic [PW-1:0]      r_ptr, w_gidx;
  logic               r_val, w_any_free, w_do_grant, w_sent_ok, w_rel;
  logic [VC_NUM-1:0]  w_free;
  logic [VP-1:0]      w_alloc_pad, w_on_pad, w_range;
  // Pad per-VC flags to the full index space so out-of-range flit_Vc_i reads as invalid
  for (genvar v = 0; v < VP; v++) begin : g_pad
    if (v < VC_NUM) begin : g_real
      assign w_alloc_pad[v] = r_state[v] == ALLOCATED;
      assign w_on_pad[v]    = on_Off_i[v];
      assign w_range[v]     = 1'b1;
    end else begin : g_none
      assign w_alloc_pad[v] = 1'b0;
      assign w_on_pad[v]    = 1'b0;
      assign w_range[v]     = 1'b0;
    end
  end
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign w_free[v]     = r_state[v] == FREE && on_Off_i[v];
    assign vc_Avail_o[v] = r_state[v] == ALLOCATED && on_Off_i[v];
  end
  assign w_sent_ok  = flit_Sent_i && w_range[flit_Vc_i] && w_alloc_pad[flit_Vc_i] && w_on_pad[flit_Vc_i];
  assign w_rel      = w_sent_ok && flit_Tail_i;
  assign w_any_free = |w_free;
  assign w_elig     = vc_Req_i & ~r_grant;
  assign w_do_grant = |w_elig && w_any_free;
  always_comb begin
    w_vc_sel = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) if (w_free[v]) w_vc_sel = VC_Size'(v);
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req_i(w_elig), .ptr_i(r_ptr), .gnt_o(w_gnt));
  always_comb begin
    w_gidx = '0;
    for (int r = 0; r < NUM_REQ; r++) if (w_gnt[r]) w_gidx = PW'(r);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '{default: FREE};
      r_grant <= '0;
      r_new   <= '0;
      r_val   <= 1'b0;
      r_ptr   <= PW'(NUM_REQ - 1);
    end else begin
      for (int v = 0; v < VC_NUM; v++)
        if (w_rel && flit_Vc_i == VC_Size'(v)) r_state[v] <= FREE;
        else if (w_do_grant && w_vc_sel == VC_Size'(v)) r_state[v] <= ALLOCATED;
      r_grant <= w_do_grant ? w_gnt : '0;
      r_new   <= w_do_grant ? w_vc_sel : '0;
      r_val   <= w_do_grant;
      if (w_do_grant) r_ptr <= w_gidx;
    end
  end
`ifdef OUTPUT_VC_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (flit_Sent_i && !w_sent_ok) r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
  assign vc_Grant_o = r_grant;
  assign vc_New_o   = r_new;
  assign vc_Val_o   = r_val;
endmodule

// File: tb/tb_output_vc_tracker.sv
// tb_output_vc_tracker: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_output_vc_tracker;
  localparam int NV = 2;
  localparam int NR = 5;
`ifdef OUTPUT_VC_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif
  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NR-1:0]                  vc_Req_i, vc_Grant_o;
  logic [params_noc::VC_Size-1:0] vc_New_o, flit_Vc_i;
  logic                           vc_Val_o, flit_Sent_i, flit_Tail_i, err_o;
  logic [NV-1:0]                  on_Off_i, vc_Avail_o;
  int n_chk = 0;
  int n_fail = 0;

  output_vc_tracker #(.VC_NUM(NV), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .vc_Req_i(vc_Req_i), .vc_Grant_o(vc_Grant_o),
    .vc_New_o(vc_New_o), .vc_Val_o(vc_Val_o), .on_Off_i(on_Off_i),
    .flit_Sent_i(flit_Sent_i), .flit_Vc_i(flit_Vc_i), .flit_Tail_i(flit_Tail_i),
    .vc_Avail_o(vc_Avail_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: VC ownership as a bit array, requester choice as a circular scan.
  bit            m_alloc [NV];
  bit            nxt [NV];
  int            m_ptr, m_new, fv, win, vi;
  logic [NR-1:0] m_gnt, el;
  logic          m_val, m_err;
  bit            ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) m_alloc[i] = 1'b0;
      m_ptr = NR - 1;
      m_gnt = '0;
      m_val = 1'b0;
      m_new = 0;
      m_err = 1'b0;
    end else begin
      vi = int'(flit_Vc_i);
      ok = flit_Sent_i && vi < NV && m_alloc[vi] && on_Off_i[vi];
      nxt = m_alloc;
      if (ok && flit_Tail_i) nxt[vi] = 1'b0;
      if (ERR_EXP == 1 && flit_Sent_i && !ok) m_err = 1'b1;
      fv = -1;
      for (int i = NV - 1; i >= 0; i--) if (!m_alloc[i] && on_Off_i[i]) fv = i;
      el = vc_Req_i & ~m_gnt;
      win = -1;
      for (int k = NR; k >= 1; k--) if (el[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      if (fv >= 0 && win >= 0) begin
        nxt[fv] = 1'b1;
        m_gnt = NR'(1) << win;
        m_val = 1'b1;
        m_new = fv;
        m_ptr = win;
      end else begin
        m_gnt = '0;
        m_val = 1'b0;
      end
      m_alloc = nxt;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [NV-1:0] ea;
      for (int i = 0; i < NV; i++) ea[i] = m_alloc[i] && on_Off_i[i];
      chk("grant", 32'(vc_Grant_o), 32'(m_gnt));
      chk("val", 32'(vc_Val_o), 32'(m_val));
      if (m_val) chk("new", 32'(vc_New_o), m_new);
      chk("avail", 32'(vc_Avail_o), 32'(ea));
      chk("err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vc_Req_i = '0;
    flit_Sent_i = 1'b0;
    flit_Tail_i = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; vc_Req_i = '0; on_Off_i = 2'b11;
    flit_Sent_i = 1'b0; flit_Vc_i = '0; flit_Tail_i = 1'b0;
    cyc(); cyc();
    chk("rst_grant", 32'(vc_Grant_o), 0);
    chk("rst_val", 32'(vc_Val_o), 0);
    chk("rst_new", 32'(vc_New_o), 0);
    chk("rst_avail", 32'(vc_Avail_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_n = 1'b1;
    cyc(); chk("post_rst_idle", 32'(vc_Grant_o), 0);
    vc_Req_i = 5'b00001;
    cyc();
    chk("t1_grant", 32'(vc_Grant_o), 1);
    chk("t1_new", 32'(vc_New_o), 0);
    chk("t1_val", 32'(vc_Val_o), 1);
    chk("t1_avail", 32'(vc_Avail_o), 1);
    vc_Req_i = '0;
    cyc(); chk("t1_pulse", 32'(vc_Grant_o), 0);
    do_reset();
    vc_Req_i = 5'b00101;
    cyc(); chk("t2_g0", 32'(vc_Grant_o), 5'b00001); chk("t2_new0", 32'(vc_New_o), 0);
    vc_Req_i = 5'b00100;
    cyc(); chk("t2_g2", 32'(vc_Grant_o), 5'b00100); chk("t2_new1", 32'(vc_New_o), 1);
    vc_Req_i = 5'b01000;
    cyc(); chk("t2_wait", 32'(vc_Grant_o), 0);
    cyc(); chk("t2_wait2", 32'(vc_Grant_o), 0); chk("t2_avail", 32'(vc_Avail_o), 3);
    flit_Sent_i = 1'b1; flit_Vc_i = 1'b1; flit_Tail_i = 1'b1;
    cyc(); chk("t3_no_bypass", 32'(vc_Grant_o), 0); chk("t3_avail", 32'(vc_Avail_o), 1);
    flit_Sent_i = 1'b0; flit_Tail_i = 1'b0;
    cyc(); chk("t3_grant", 32'(vc_Grant_o), 5'b01000); chk("t3_new", 32'(vc_New_o), 1);
    chk("t3_err", 32'(err_o), 0);
    vc_Req_i = '0;
    cyc();
    do_reset();
    on_Off_i = 2'b10; vc_Req_i = 5'b00010;
    cyc(); chk("t4_grant", 32'(vc_Grant_o), 5'b00010); chk("t4_new", 32'(vc_New_o), 1);
    vc_Req_i = '0; on_Off_i = 2'b00;
    cyc(); chk("t4_avail_off", 32'(vc_Avail_o), 0);
    vc_Req_i = 5'b00001;
    cyc(); cyc(); chk("t4_off_wait", 32'(vc_Grant_o), 0);
    on_Off_i = 2'b01;
    cyc(); chk("t4_on", 32'(vc_Grant_o), 5'b00001); chk("t4_on_new", 32'(vc_New_o), 0);
    vc_Req_i = '0; on_Off_i = 2'b11;
    cyc();
    do_reset();
    flit_Sent_i = 1'b1; flit_Vc_i = '0; flit_Tail_i = 1'b1;
    cyc(); flit_Sent_i = 1'b0; flit_Tail_i = 1'b0;
    chk("t5_err", 32'(err_o), ERR_EXP); chk("t5_avail", 32'(vc_Avail_o), 0);
    cyc(); cyc(); chk("t5_err_sticky", 32'(err_o), ERR_EXP);
    vc_Req_i = 5'b00001;
    cyc(); vc_Req_i = '0;
    cyc(); chk("t6_avail", 32'(vc_Avail_o), 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_avail", 32'(vc_Avail_o), 0); chk("t6_async_err", 32'(err_o), 0);
    cyc(); rst_n = 1'b1; vc_Req_i = 5'b00100;
    cyc(); chk("t6_grant", 32'(vc_Grant_o), 5'b00100); chk("t6_new", 32'(vc_New_o), 0);
    vc_Req_i = '0;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
